// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter: round-robin sharing of the single-command SDRAM controller host port.
// Optional abort timer enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_host_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 20000,
   parameter int TW      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ-1:0]   req_we,
   input  logic [2*NREQ-1:0] req_bank,
   input  logic [22*NREQ-1:0] req_addr,
   input  logic [16*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [15:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              sd_wcmd,
   output logic              sd_rcmd,
   output logic [1:0]        sd_bank,
   output logic [21:0]       sd_addr,
   output logic [15:0]       sd_din,
   input  logic              sd_wdone,
   input  logic              sd_rdone,
   input  logic [15:0]       sd_dout
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t state, state_n;
   logic [1:0] rr_ptr, rr_n, owner, owner_n, pick, j;
   logic [2:0] s;
   logic found, done, tmo;
   logic [3:0] vld_a, we_a, ready4, rsp4;
   logic [1:0] bank_a [4];
   logic [21:0] addr_a [4];
   logic [15:0] din_a [4];
   logic [15:0] rdata_n, din_n;
   logic [21:0] addr_n;
   logic [1:0] bank_n;
   logic err_n, wcmd_n, rcmd_n;

   // unpack requester fields into fixed 4-entry tables so a 2-bit index fits any NREQ
   always_comb begin
      vld_a = '0;
      we_a = '0;
      for (int i = 0; i < 4; i++) begin
         bank_a[i] = '0;
         addr_a[i] = '0;
         din_a[i] = '0;
      end
      for (int i = 0; i < NREQ; i++) begin
         vld_a[i] = req_valid[i];
         we_a[i] = req_we[i];
         bank_a[i] = req_bank[2*i +: 2];
         addr_a[i] = req_addr[22*i +: 22];
         din_a[i] = req_wdata[16*i +: 16];
      end
   end

   // scan downwards so the requester closest to rr_ptr wins last
   always_comb begin
      found = 1'b0;
      pick = '0;
      s = '0;
      j = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         s = {1'b0, rr_ptr} + 3'(i);
         j = (s >= 3'(NREQ)) ? 2'(s - 3'(NREQ)) : s[1:0];
         if (vld_a[j]) begin
            found = 1'b1;
            pick = j;
         end
      end
   end

   assign done = (sd_wcmd & sd_wdone) | (sd_rcmd & sd_rdone);

`ifdef SDRAM_ARB_TIMEOUT_EN
   logic [TW-1:0] cnt;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (state == ISSUE) ? cnt + 1'b1 : '0;
   assign tmo = (state == ISSUE) && (cnt == TW'(TIMEOUT-1));
`else
   logic unused_cfg;
   assign unused_cfg = ^{32'(TIMEOUT), 32'(TW)};
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         owner <= '0;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
         sd_wcmd <= 1'b0;
         sd_rcmd <= 1'b0;
         sd_bank <= '0;
         sd_addr <= '0;
         sd_din <= '0;
      end else begin
         state <= state_n;
         rr_ptr <= rr_n;
         owner <= owner_n;
         req_ready <= ready4[NREQ-1:0];
         rsp_valid <= rsp4[NREQ-1:0];
         rsp_rdata <= rdata_n;
         rsp_err <= err_n;
         sd_wcmd <= wcmd_n;
         sd_rcmd <= rcmd_n;
         sd_bank <= bank_n;
         sd_addr <= addr_n;
         sd_din <= din_n;
      end

   always_comb
      state_n = (state == IDLE)  ? (found ? ISSUE : IDLE) :
                (state == ISSUE) ? ((done | tmo) ? RESP : ISSUE) : IDLE;

   // a matching done in the timeout cycle still completes normally (err stays 0)
   always_comb begin
      ready4 = '0;
      rsp4 = '0;
      owner_n = owner;
      rr_n = rr_ptr;
      rdata_n = rsp_rdata;
      err_n = rsp_err;
      wcmd_n = sd_wcmd;
      rcmd_n = sd_rcmd;
      bank_n = sd_bank;
      addr_n = sd_addr;
      din_n = sd_din;
      if (state == IDLE && found) begin
         ready4[pick] = 1'b1;
         owner_n = pick;
         rr_n = (pick == 2'(NREQ-1)) ? 2'd0 : pick + 2'd1;
         bank_n = bank_a[pick];
         addr_n = addr_a[pick];
         din_n = din_a[pick];
         wcmd_n = we_a[pick];
         rcmd_n = ~we_a[pick];
      end
      if (state == ISSUE && (done || tmo)) begin
         wcmd_n = 1'b0;
         rcmd_n = 1'b0;
         rsp4[owner] = 1'b1;
         err_n = ~done;
         rdata_n = (done && sd_rcmd) ? sd_dout : rsp_rdata;
      end
   end
endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb_sdram_host_arbiter: scoreboard bench for sdram_host_arbiter (NREQ=2, TIMEOUT=50).
module tb_sdram_host_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] req_valid = '0, req_we = '0, req_ready, rsp_valid, sd_bank;
   logic [3:0] req_bank = '0;
   logic [43:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [15:0] rsp_rdata, sd_din, sd_dout = '0;
   logic [21:0] sd_addr;
   logic rsp_err, sd_wcmd, sd_rcmd, sd_wdone = 1'b0, sd_rdone = 1'b0;
   int total = 0, bad = 0;
   int g, lat, n;
   logic [21:0] cur_addr [2];
   logic [15:0] last_rd = '0;
   typedef struct packed {logic [1:0] vld; logic [15:0] rd; logic err;} rsp_t;
   rsp_t exp_q[$];
   rsp_t e_m;

   sdram_host_arbiter #(.NREQ(2), .TIMEOUT(50), .TW(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_bank(req_bank),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .sd_wcmd(sd_wcmd), .sd_rcmd(sd_rcmd),
      .sd_bank(sd_bank), .sd_addr(sd_addr), .sd_din(sd_din), .sd_wdone(sd_wdone),
      .sd_rdone(sd_rdone), .sd_dout(sd_dout)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] all_out();
      return 64'({req_ready, rsp_valid, rsp_rdata, rsp_err, sd_wcmd, sd_rcmd, sd_bank, sd_addr, sd_din});
   endfunction

   always @(negedge clk)
      if (!rst && rsp_valid != 2'b00) begin
         if (exp_q.size() == 0) chk("rsp_unexp", 64'(rsp_valid), 64'd0);
         else begin
            e_m = exp_q.pop_front();
            chk("rsp_owner", 64'(rsp_valid), 64'(e_m.vld));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e_m.rd));
            chk("rsp_err", 64'(rsp_err), 64'(e_m.err));
         end
      end

   task automatic set_req(int r, bit v, bit we, logic [1:0] b, logic [21:0] a, logic [15:0] d);
      req_valid[r] = v;
      req_we[r] = we;
      req_bank[2*r +: 2] = b;
      req_addr[22*r +: 22] = a;
      req_wdata[16*r +: 16] = d;
   endtask

   task automatic expect_rsp(int r, bit rd, logic [15:0] d, bit err);
      exp_q.push_back('{vld: 2'(1 << r), rd: rd ? d : last_rd, err: err});
      if (rd) last_rd = d;
   endtask

   task automatic wait_grant(output int gg, output int ll);
      gg = -1;
      ll = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (req_ready != 2'b00) begin
            gg = req_ready[1] ? 1 : 0;
            ll = i;
            break;
         end
      end
      if (gg < 0) chk("grant_timeout", 64'(req_ready), 64'd1);
   endtask

   task automatic complete(bit rd, logic [15:0] d);
      if (rd) begin
         sd_rdone = 1'b1;
         sd_dout = d;
      end else sd_wdone = 1'b1;
      @(negedge clk);
      sd_rdone = 1'b0;
      sd_wdone = 1'b0;
      sd_dout = 16'($urandom);
      chk("cmd_drop", 64'({sd_wcmd, sd_rcmd}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_out", all_out(), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      // write, grant latency, held command fields
      set_req(0, 1, 1, 2'd1, 22'd100, 16'h0092);
      expect_rsp(0, 0, 16'h0, 0);
      wait_grant(g, lat);
      chk("t1_grant", 64'(g), 64'd0);
      chk("t1_lat", 64'(lat), 64'd1);
      chk("t1_cmd", 64'({sd_wcmd, sd_rcmd, sd_bank, sd_addr, sd_din}), 64'({1'b1, 1'b0, 2'd1, 22'd100, 16'h0092}));
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t1_ready_pulse", 64'(req_ready), 64'd0);
      repeat (2) @(negedge clk);
      chk("t1_hold", 64'({sd_wcmd, sd_rcmd, sd_bank, sd_addr, sd_din}), 64'({1'b1, 1'b0, 2'd1, 22'd100, 16'h0092}));
      complete(0, 16'h0);
      // read
      set_req(0, 1, 0, 2'd2, 22'd1000, 16'h0);
      expect_rsp(0, 1, 16'h00A4, 0);
      wait_grant(g, lat);
      chk("t2_grant", 64'(g), 64'd0);
      chk("t2_cmd", 64'({sd_wcmd, sd_rcmd, sd_bank, sd_addr}), 64'({1'b0, 1'b1, 2'd2, 22'd1000}));
      req_valid[0] = 1'b0;
      @(negedge clk);
      complete(1, 16'h00A4);
      // single req1 while rr_ptr points at it
      set_req(1, 1, 1, 2'd3, 22'h3FFFFF, 16'hBEEF);
      expect_rsp(1, 0, 16'h0, 0);
      wait_grant(g, lat);
      chk("t3_grant", 64'(g), 64'd1);
      chk("t3_cmd", 64'({sd_bank, sd_addr, sd_din}), 64'({2'd3, 22'h3FFFFF, 16'hBEEF}));
      req_valid[1] = 1'b0;
      complete(0, 16'h0);
      // rotation with both continuously valid
      cur_addr[0] = 22'd10;
      cur_addr[1] = 22'd20;
      set_req(0, 1, 1, 2'd0, cur_addr[0], 16'h1111);
      set_req(1, 1, 1, 2'd1, cur_addr[1], 16'h2222);
      for (int k = 0; k < 4; k++) begin
         expect_rsp(k % 2, 0, 16'h0, 0);
         wait_grant(g, lat);
         chk("rot_grant", 64'(g), 64'(k % 2));
         chk("rot_addr", 64'(sd_addr), 64'(cur_addr[k % 2]));
         cur_addr[k % 2] = cur_addr[k % 2] + 22'd1;
         req_addr[22*(k % 2) +: 22] = cur_addr[k % 2];
         @(negedge clk);
         complete(0, 16'h0);
      end
      req_valid = 2'b00;
      set_req(1, 1, 1, 2'd1, 22'd300, 16'h3333);
      expect_rsp(1, 0, 16'h0, 0);
      wait_grant(g, lat);
      chk("alone_grant", 64'(g), 64'd1);
      chk("alone_lat", 64'(lat), 64'd2);
      req_valid[1] = 1'b0;
      complete(0, 16'h0);
      // wrong-type done during a read, then done in RESP/IDLE
      set_req(0, 1, 0, 2'd0, 22'd555, 16'h0);
      expect_rsp(0, 1, 16'h1234, 0);
      wait_grant(g, lat);
      req_valid[0] = 1'b0;
      sd_wdone = 1'b1;
      @(negedge clk);
      sd_wdone = 1'b0;
      chk("wt_rcmd", 64'(sd_rcmd), 64'd1);
      chk("wt_norsp", 64'(rsp_valid), 64'd0);
      @(negedge clk);
      chk("wt_norsp2", 64'({rsp_valid, sd_rcmd}), 64'd1);
      complete(1, 16'h1234);
      sd_rdone = 1'b1;
      sd_wdone = 1'b1;
      sd_dout = 16'hFFFF;
      repeat (2) @(negedge clk);
      sd_rdone = 1'b0;
      sd_wdone = 1'b0;
      chk("idle_done", 64'({rsp_valid, rsp_rdata}), 64'({2'b00, 16'h1234}));
      // done coincident with the grant edge is ignored
      set_req(1, 1, 0, 2'd2, 22'd600, 16'h0);
      expect_rsp(1, 1, 16'h4321, 0);
      sd_rdone = 1'b1;
      sd_dout = 16'hDEAD;
      wait_grant(g, lat);
      sd_rdone = 1'b0;
      req_valid[1] = 1'b0;
      chk("grant_done_g", 64'(g), 64'd1);
      @(negedge clk);
      chk("grant_done_hold", 64'({rsp_valid, sd_rcmd}), 64'd1);
      complete(1, 16'h4321);
      // async reset mid-ISSUE
      set_req(0, 1, 0, 2'd1, 22'd77, 16'h0);
      wait_grant(g, lat);
      set_req(1, 1, 1, 2'd2, 22'd88, 16'h5555);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("arst_out", all_out(), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      expect_rsp(0, 1, 16'h7777, 0);
      wait_grant(g, lat);
      chk("arst_first", 64'(g), 64'd0);
      chk("arst_addr", 64'(sd_addr), 64'd77);
      req_valid[0] = 1'b0;
      complete(1, 16'h7777);
      expect_rsp(1, 0, 16'h0, 0);
      wait_grant(g, lat);
      chk("arst_second", 64'(g), 64'd1);
      req_valid[1] = 1'b0;
      complete(0, 16'h0);
      // never-completing write
      set_req(0, 1, 1, 2'd0, 22'd9, 16'h0009);
`ifdef SDRAM_ARB_TIMEOUT_EN
      expect_rsp(0, 0, 16'h0, 1);
`endif
      wait_grant(g, lat);
      req_valid[0] = 1'b0;
      n = 1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!sd_wcmd) break;
         n++;
      end
`ifdef SDRAM_ARB_TIMEOUT_EN
      chk("tmo_len", 64'(n), 64'd50);
`else
      chk("no_tmo_len", 64'(n), 64'd61);
      expect_rsp(0, 0, 16'h0, 0);
      complete(0, 16'h0);
`endif
      repeat (3) @(negedge clk);
      chk("q_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sdram_host_arbiter.md
Name: sdram_host_arbiter

Overview:
- Shares the single-command host port of the SDRAM controller between NREQ requesters, using round-robin arbitration.
- Each granted transaction is one 16-bit write or read: bank, 22-bit address, data.
- The arbiter holds the level-sensitive write/read command to the controller until the matching done pulse arrives, then returns a one-cycle response to the owning requester.
- It sits between the host logic (test sequencers, display fetch) and the SDRAM controller.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- TIMEOUT, 20000, cycles in ISSUE before abort. Used only with SDRAM_ARB_TIMEOUT_EN; must exceed controller init plus one transaction.
- TW, 16, width of the timeout counter.

Ports:
- clk  in  1  system clock; also the SDRAM clock domain.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_bank  in  2*NREQ  bank, packed; requester i uses bits [2i+1:2i].
- req_addr  in  22*NREQ  {row[21:9], col[8:0]}, packed.
- req_wdata  in  16*NREQ  write data, packed.
- req_ready  out  NREQ  one-cycle accept pulse.
- rsp_valid  out  NREQ  one-cycle completion pulse.
- rsp_rdata  out  16  read data; shared by all requesters.
- rsp_err  out  1  completion was a timeout abort; qualified by rsp_valid.
- sd_wcmd  out  1  write command level to the controller.
- sd_rcmd  out  1  read command level to the controller.
- sd_bank  out  2  bank to the controller.
- sd_addr  out  22  address to the controller.
- sd_din  out  16  write data to the controller.
- sd_wdone  in  1  controller write-complete pulse.
- sd_rdone  in  1  controller read-complete pulse.
- sd_dout  in  16  controller read data; valid when sd_rdone is high.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, rr_ptr=0, and all outputs 0. That covers req_ready, rsp_valid, rsp_rdata, rsp_err, sd_wcmd, sd_rcmd, sd_bank, sd_addr and sd_din.
- Reset mid-transaction drops the command immediately. No response is issued for the aborted transaction.
- FSM states: IDLE, ISSUE, RESP.

IDLE:
- Choose the first set req_valid[k], scanning k = rr_ptr, rr_ptr+1, ... modulo NREQ.
- If one is found, the next cycle is ISSUE:
  - owner is latched as k;
  - req_ready[k] is high for exactly that cycle;
  - sd_bank, sd_addr and sd_din take requester k's fields as sampled at the granting edge;
  - sd_wcmd = req_we[k] and sd_rcmd = ~req_we[k];
  - rr_ptr becomes (k+1) mod NREQ.
- Grant latency: req_valid sampled high in IDLE produces req_ready on the next edge.
- Requesters hold valid and fields until they see req_ready.
- A requester deasserts or changes req_valid in the cycle after its req_ready.

ISSUE:
- sd_bank, sd_addr, sd_din and the command levels are held constant.
- Completion is sd_wdone for a write or sd_rdone for a read. A done pulse of the wrong type is ignored.
- On completion the next cycle is RESP:
  - both command bits go to 0;
  - rsp_valid[owner] = 1;
  - rsp_rdata = sd_dout for a read; rsp_rdata is unchanged for a write;
  - rsp_err = 0.
- Command bits are therefore low from the cycle after done. The controller never re-samples a stale command at its idle check.

RESP:
- Lasts one cycle, then IDLE. rsp_valid returns to 0.
- The minimum gap between consecutive grants is 1 IDLE cycle.
- rsp_rdata holds until the next RESP.
- A requester may re-request while its own response is outstanding. It is arbitrated normally in the next IDLE.

Boundary conditions:
- All requesters valid: service order is strict rotation, so no requester starves.
- A single requester valid: it is granted every transaction, regardless of rr_ptr.
- Done arriving in IDLE or RESP: ignored.
- Done arriving in the same cycle as the grant: ignored, because completion only counts in ISSUE.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - a TW-bit counter clears on entry to ISSUE and increments every ISSUE cycle;
  - if it reaches TIMEOUT-1 without a matching done, the next cycle is RESP with rsp_valid[owner]=1, rsp_err=1, rsp_rdata unchanged and commands dropped;
  - a done arriving in the same cycle as the timeout wins, giving a normal completion with rsp_err=0.
- Undefined: no counter exists, ISSUE waits indefinitely, and rsp_err is a constant 0.

Test Plan:
- Reset, then req_valid[0]=1, we=1, bank=1, addr=100, wdata=16'h0092:
  - req_ready[0] pulses one cycle later;
  - sd_wcmd=1 with sd_bank=1, sd_addr=100, sd_din=16'h0092 held until sd_wdone;
  - next cycle sd_wcmd=0 and rsp_valid[0]=1.
- Read: req0 read bank=2, addr=1000; model returns sd_rdone with sd_dout=16'h00A4:
  - rsp_rdata=16'h00A4 and rsp_valid[0] pulses;
  - sd_rcmd drops the cycle after sd_rdone.
- Rotation: req0 and req1 held valid continuously for 4 transactions:
  - grants alternate 0,1,0,1;
  - a single req1 alone after that is granted immediately.
- Wrong-type done: sd_wdone pulsed during a read ISSUE:
  - no response and sd_rcmd stays high;
  - a later sd_rdone completes normally.
- Async rst asserted mid-ISSUE:
  - all outputs are 0 immediately (no clock edge);
  - after release, the held-valid req0 is granted first.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT=50, never pulse done:
  - the command drops after 50 ISSUE cycles;
  - rsp_valid[owner]=1 and rsp_err=1.
